// File: rtl/sum_differentiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_differentiator_pkg
// Description : Shared constants, state encoding and the narrowing/saturation
//               helper for the running-sum differentiator.
//               Contents:
//                 SUM_W      - width of the accumulated stream (21)
//                 SMP_W      - width of a recovered signed sample (13)
//                 state_t    - PRIME (no reference held) / RUN
//                 sat_narrow - SUM_W difference -> {SMP_W sample, overflow}
// Revision    : 1.0 - initial release
// ============================================================================
package sum_differentiator_pkg;

    localparam int SUM_W = 21;
    localparam int SMP_W = 13;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    // A difference fits the narrow signed range when every bit from the MSB
    // down to the narrow sign bit is identical. Otherwise clamp toward the
    // sign of the wide value. The overflow flag is the LSB of the result.
    function automatic logic [SMP_W:0] sat_narrow(input logic [SUM_W-1:0] d);
        logic [SUM_W-SMP_W:0] upper;
        logic                 ovf;
        logic [SMP_W-1:0]     smp;
        upper = d[SUM_W-1:SMP_W-1];
        ovf   = !((&upper) || !(|upper));
        if (!ovf) begin
            smp = d[SMP_W-1:0];
        end else if (d[SUM_W-1]) begin
            smp = {1'b1, {(SMP_W-1){1'b0}}};
        end else begin
            smp = {1'b0, {(SMP_W-1){1'b1}}};
        end
        return {smp, ovf};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_differentiator_diff_range_sat.sv
`default_nettype none
// ============================================================================
// Module      : diff_range_sat
// Description : Combinational range check and saturation of a wide two's
//               complement difference down to a narrow signed sample.
// Ports       : d_i      [IN_W]  wide difference (stage-1 register)
//               sample_o [OUT_W] narrowed / saturated sample
//               ovf_o            difference was outside the narrow range
// Revision    : 1.0 - initial release
// ============================================================================
module diff_range_sat
    import sum_differentiator_pkg::*;
#(
    parameter int IN_W  = SUM_W,
    parameter int OUT_W = SMP_W
) (
    input  logic [IN_W-1:0]  d_i,
    output logic [OUT_W-1:0] sample_o,
    output logic             ovf_o
);

    generate
        if (IN_W == SUM_W && OUT_W == SMP_W) begin : g_pkg_fn
            // Default widths: reuse the shared helper so the rule lives once.
            logic [SMP_W:0] w_res;
            assign w_res    = sat_narrow(d_i);
            assign sample_o = w_res[SMP_W:1];
            assign ovf_o    = w_res[0];
        end else begin : g_generic
            logic [IN_W-OUT_W:0] w_upper;
            assign w_upper  = d_i[IN_W-1:OUT_W-1];
            assign ovf_o    = ~((&w_upper) | ~(|w_upper));
            assign sample_o = !ovf_o       ? d_i[OUT_W-1:0] :
                              d_i[IN_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                             {1'b0, {(OUT_W-1){1'b1}}};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sum_differentiator.sv
`default_nettype none
// ============================================================================
// Module      : sum_differentiator
// Description : Recovers signed samples from a running-sum stream by first
//               difference. Stage 1 registers S - prev (modular), stage 2
//               range-checks/saturates and presents the sample.
// Ports       : clk        rising-edge clock
//               rst_n      async active-low reset
//               S   [IN_W] accumulated value
//               ce         S valid this cycle
//               clr        sync restart (re-prime, clear errors), beats ce
//               A  [OUT_W] recovered sample
//               valid      one-cycle pulse per recovered sample
//               range_err  sticky out-of-range flag
//               err_cnt    saturating count of out-of-range differences
//               primed     reference value held (state RUN)
// Revision    : 1.0 - initial release
// ============================================================================
module sum_differentiator
    import sum_differentiator_pkg::*;
#(
    parameter int IN_W  = SUM_W,
    parameter int OUT_W = SMP_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  S,
    input  logic             ce,
    input  logic             clr,
    output logic [OUT_W-1:0] A,
    output logic             valid,
    output logic             range_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             primed
);

    state_t             state_q;
    logic [IN_W-1:0]    prev_q;
    logic [IN_W-1:0]    diff_q;
    logic               s1_valid_q;
    logic [OUT_W-1:0]   a_q;
    logic               valid_q;
    logic               range_err_q;
    logic [CNT_W-1:0]   err_cnt_q;

    logic [IN_W-1:0]    diff_d;
    logic [CNT_W-1:0]   err_cnt_d;
    logic [OUT_W-1:0]   w_sample;
    logic               w_ovf;

    // Modular subtraction: an accumulator wrap still yields the true step.
    assign diff_d    = S - prev_q;
    assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

    diff_range_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .d_i      (diff_q),
        .sample_o (w_sample),
        .ovf_o    (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRIME;
            prev_q      <= '0;
            diff_q      <= '0;
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            // Stage 2 always drains, even on the clr cycle.
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                a_q <= w_sample;
                if (w_ovf) begin
                    range_err_q <= 1'b1;
                    err_cnt_q   <= err_cnt_d;
                end
            end

            if (clr) begin
                // Overrides any error update above; S on this cycle is dropped.
                state_q     <= PRIME;
                prev_q      <= '0;
                s1_valid_q  <= 1'b0;
                range_err_q <= 1'b0;
                err_cnt_q   <= '0;
            end else begin
                s1_valid_q <= 1'b0;
                if (ce) begin
                    case (state_q)
                        PRIME: begin
                            prev_q  <= S;
                            state_q <= RUN;
                        end
                        RUN: begin
                            diff_q     <= diff_d;
                            s1_valid_q <= 1'b1;
                            prev_q     <= S;
                        end
                        default: state_q <= PRIME;
                    endcase
                end
            end
        end
    end

    assign A         = a_q;
    assign valid     = valid_q;
    assign range_err = range_err_q;
    assign err_cnt   = err_cnt_q;
    assign primed    = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_sum_differentiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_differentiator
// Description : Directed self-checking bench for sum_differentiator. Inputs
//               change on the falling edge; outputs are sampled on the falling
//               edge. Every recovered sample is matched against a queue of
//               hand-computed expected values; a valid with nothing expected
//               is a miscompare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_differentiator;

    localparam int IN_W  = 21;
    localparam int OUT_W = 13;
    localparam int CNT_W = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  r_S   = '0;
    logic             r_ce  = 1'b0;
    logic             r_clr = 1'b0;
    logic [OUT_W-1:0] w_A;
    logic             w_valid;
    logic             w_range_err;
    logic [CNT_W-1:0] w_err_cnt;
    logic             w_primed;

    int n_vec = 0;
    int n_err = 0;
    logic [OUT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    sum_differentiator #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .S         (r_S),
        .ce        (r_ce),
        .clr       (r_clr),
        .A         (w_A),
        .valid     (w_valid),
        .range_err (w_range_err),
        .err_cnt   (w_err_cnt),
        .primed    (w_primed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at a falling edge, return at the next one.
    task automatic cyc(input logic ce, input logic clr, input logic [IN_W-1:0] s);
        r_ce  = ce;
        r_clr = clr;
        r_S   = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    // Output monitor: every valid must consume one expected sample.
    always @(negedge clk) begin
        if (w_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", w_valid, 1'b0);
            else                   chk("A", w_A, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0]  sum;
        logic [OUT_W-1:0] smp;

        // ---------------- reset ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_A",       w_A,         0);
        chk("rst_valid",   w_valid,     0);
        chk("rst_err",     w_range_err, 0);
        chk("rst_cnt",     w_err_cnt,   0);
        chk("rst_primed",  w_primed,    0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- prime + basic ----------------
        cyc(1'b1, 1'b0, 21'd0);
        chk("prime_primed", w_primed, 1);
        chk("prime_novalid", w_valid, 0);
        exp_q.push_back(13'd5);
        cyc(1'b1, 1'b0, 21'd5);
        chk("basic_novalid", w_valid, 0);
        exp_q.push_back(13'd7);
        cyc(1'b1, 1'b0, 21'd12);
        exp_q.push_back(13'h1FF6);
        cyc(1'b1, 1'b0, 21'd2);
        idle(3);
        chk("hold_A", w_A, 13'h1FF6);
        chk("hold_valid", w_valid, 0);
        chk("basic_drain", exp_q.size(), 0);

        // ---------------- back-to-back stream ----------------
        cyc(1'b0, 1'b1, '0);
        sum = 21'h123456;
        cyc(1'b1, 1'b0, sum);
        for (int k = 1; k <= 100; k++) begin
            smp = OUT_W'($urandom_range(0, 8191));
            sum = sum + {{(IN_W-OUT_W){smp[OUT_W-1]}}, smp};
            exp_q.push_back(smp);
            cyc(1'b1, 1'b0, sum);
            if (k >= 2) chk("stream_valid", w_valid, 1);
        end
        idle(3);
        chk("stream_drain", exp_q.size(), 0);
        chk("stream_err", w_range_err, 0);

        // ---------------- wrap-around ----------------
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 21'h0FFFFF);
        exp_q.push_back(13'd5);
        cyc(1'b1, 1'b0, 21'h100004);
        idle(3);
        chk("wrap1_err", w_range_err, 0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 21'h1FFFFE);
        exp_q.push_back(13'd3);
        cyc(1'b1, 1'b0, 21'h000001);
        idle(3);
        chk("wrap2_err", w_range_err, 0);
        chk("wrap_drain", exp_q.size(), 0);

        // ---------------- overflow / saturation ----------------
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 21'd0);
        exp_q.push_back(13'h0FFF);
        cyc(1'b1, 1'b0, 21'd5000);
        idle(2);
        chk("ovf_pos_err", w_range_err, 1);
        chk("ovf_pos_cnt", w_err_cnt, 1);
        exp_q.push_back(13'h1000);
        cyc(1'b1, 1'b0, 21'd0);
        idle(2);
        chk("ovf_neg_cnt", w_err_cnt, 2);
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back((i % 2 == 0) ? 13'h0FFF : 13'h1000);
            cyc(1'b1, 1'b0, (i % 2 == 0) ? 21'd5000 : 21'd0);
        end
        idle(3);
        chk("ovf_sat_cnt", w_err_cnt, 8'hFF);
        chk("ovf_sat_err", w_range_err, 1);
        chk("ovf_drain", exp_q.size(), 0);

        // ---------------- clr beats ce ----------------
        cyc(1'b1, 1'b1, 21'd777);
        chk("clr_primed", w_primed, 0);
        chk("clr_err", w_range_err, 0);
        chk("clr_cnt", w_err_cnt, 0);
        cyc(1'b1, 1'b0, 21'd800);
        chk("clr_reprime", w_primed, 1);
        exp_q.push_back(13'd10);
        cyc(1'b1, 1'b0, 21'd810);
        idle(3);
        chk("clr_drain", exp_q.size(), 0);

        // ---------------- async reset mid-stream ----------------
        cyc(1'b1, 1'b0, 21'd850);   // diff 40 now sits in stage 1
        r_ce  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_A", w_A, 0);
        chk("arst_valid", w_valid, 0);
        chk("arst_primed", w_primed, 0);
        chk("arst_cnt", w_err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        cyc(1'b1, 1'b0, 21'd5);
        idle(3);
        chk("arst_reprime", w_primed, 1);
        exp_q.push_back(13'd2);
        cyc(1'b1, 1'b0, 21'd7);
        idle(3);
        chk("arst_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
